se_pool_ctrl: RTL
=================

SE_POOL_CTRL -- requirements
Module: se_pool_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width.
REQ-002 SHALL have parameter IN_HEIGHT, default 2, rows per channel.
REQ-003 SHALL have parameter IN_WIDTH, default 2, columns per channel.
REQ-004 SHALL have parameter CHANNELS, default 2, channel count; TOTAL = IN_HEIGHT*IN_WIDTH*CHANNELS.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 50, watchdog limit in WAIT.
REQ-006 SHALL have port clk, input, 1, the only clock.
REQ-007 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port start, input, 1, begin one frame.
REQ-009 SHALL have ports busy and done, output, 1 each: frame in progress; 1-cycle completion pulse.
REQ-010 SHALL have ports s_data (input, DATA_WIDTH), s_valid (input, 1), s_ready (output, 1): channel-major pixel stream.
REQ-011 SHALL have ports pool_clr, pool_in_valid (output, 1) and pool_in_data (output, DATA_WIDTH): drive to pooling unit.
REQ-012 SHALL have ports pool_out_data (input, DATA_WIDTH) and pool_out_valid (input, 1): per-channel averages from pooling unit.
REQ-013 SHALL have ports m_data (output, DATA_WIDTH), m_valid (output, 1), m_ready (input, 1), m_last (output, 1), m_chan (output, $clog2(CHANNELS), min 1): squeeze vector to excitation stage.
REQ-014 SHALL have port err_timeout, output, 1, sticky watchdog flag.

Function
REQ-015 SHALL implement FSM states IDLE, FEED, WAIT, DRAIN; busy = 1 in every state except IDLE.
REQ-016 IDLE: start=1 -> FEED; SHALL pulse pool_clr for exactly that transition cycle and clear input count, result count, drain index; start outside IDLE SHALL be ignored.
REQ-017 FEED: s_ready = 1; each s_valid&&s_ready handshake SHALL register s_data onto pool_in_data with pool_in_valid=1 the following cycle (latency 1); no handshake -> pool_in_valid=0 next cycle.
REQ-018 FEED: after the TOTAL-th handshake SHALL go to WAIT; s_ready SHALL be 0 from that cycle onward.
REQ-019 In FEED and WAIT, each pool_out_valid SHALL store pool_out_data into result buffer[result count] and increment count; pulses beyond CHANNELS SHALL be dropped; pool_out_valid in IDLE/DRAIN ignored.
REQ-020 WAIT: when result count reaches CHANNELS -> DRAIN.
REQ-021 DRAIN: m_valid=1, m_data=buffer[idx], m_chan=idx, m_last=(idx==CHANNELS-1); m_data/m_chan SHALL hold stable while m_valid && !m_ready.
REQ-022 DRAIN: m_valid&&m_ready advances idx; handshake with m_last -> IDLE, done=1 for the next single cycle.
REQ-023 Buffer SHALL store values unmodified (no arithmetic, no width change).
REQ-024 Same-cycle start and done: done pulses, start is ignored (FSM already IDLE only next cycle).

Reset
REQ-025 rst=1 SHALL immediately force IDLE and all counters/buffer to 0; busy, done, s_ready, pool_in_valid, pool_in_data, m_valid, m_data, m_last, m_chan, err_timeout = 0; pool_clr = 0.
REQ-026 rst mid-frame SHALL abort without done; first start after rst release behaves as REQ-016.

Configuration
REQ-027 With SE_POOL_CTRL_TIMEOUT_EN defined: a counter SHALL count WAIT cycles without a new pool_out_valid (reset on each one); reaching TIMEOUT_CYCLES SHALL set err_timeout (sticky until rst) and return to IDLE without done.
REQ-028 Without SE_POOL_CTRL_TIMEOUT_EN: no watchdog logic; err_timeout tied 0; WAIT waits indefinitely.

Verification (CHANNELS=2, 2x2, DATA_WIDTH=16)
REQ-029 start, stream 1,2,3,4,10,20,30,40, model pool returns 2,25, m_ready=1 -> m_data 2 (m_chan 0), 25 (m_chan 1, m_last=1), done pulse 1 cycle, pool_clr pulse once.
REQ-030 Same frame, m_ready low 3 cycles on first output -> m_data=2 held stable; sequence 2,25 intact.
REQ-031 s_valid gapped every other cycle -> pool_in_valid mirrors handshakes 1 cycle later, exactly 8 pulses; s_ready=0 after 8th.
REQ-032 Pool returns 3 results (2,25,99) -> 99 dropped; drain emits only 2,25.
REQ-033 rst after 5 inputs -> all outputs 0 immediately, no done; new frame of all 100 -> outputs 100,100.
REQ-034 With SE_POOL_CTRL_TIMEOUT_EN, pool returns one result only -> err_timeout=1 after 50 WAIT cycles, FSM IDLE, no done; without macro -> busy stays 1.

Source files
------------

// File: rtl/se_pool_ctrl.sv
// se_pool_ctrl: frame sequencer for a squeeze-excitation pooling stage.
// Streams a channel-major frame into an external pooling unit, collects one
// average per channel, then drains the squeeze vector to the excitation stage.
// Optional watchdog in WAIT is enabled by defining SE_POOL_CTRL_TIMEOUT_EN.
module se_pool_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int IN_HEIGHT      = 2,
  parameter int IN_WIDTH       = 2,
  parameter int CHANNELS       = 2,
  parameter int TIMEOUT_CYCLES = 50,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  pool_clr,
  output logic                  pool_in_valid,
  output logic [DATA_WIDTH-1:0] pool_in_data,
  input  logic [DATA_WIDTH-1:0] pool_out_data,
  input  logic                  pool_out_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CW-1:0]         m_chan,
  output logic                  err_timeout
);

  localparam int TOTAL = IN_HEIGHT * IN_WIDTH * CHANNELS;
  localparam int IW    = $clog2(TOTAL + 1);
  localparam int RW    = $clog2(CHANNELS + 1);

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;

  state_t                  state, state_nx;
  logic [IW-1:0]           in_cnt;
  logic [RW-1:0]           res_cnt;
  logic [CW-1:0]           idx;
  logic [CW-1:0]           wr_idx;
  logic [DATA_WIDTH-1:0]   res_buf [CHANNELS];
  logic                    s_hs, m_hs, start_acc, res_wr, last_in, last_chan;
  logic                    res_full, timeout_hit;

  // Handshake and qualifier decode shared by the FSM and datapath.
  // done is only ever high in IDLE, so masking start with it drops a start
  // that coincides with the completion pulse.
  always_comb begin
    s_hs      = (state == FEED) && s_valid;
    m_hs      = (state == DRAIN) && m_ready;
    start_acc = (state == IDLE) && start && !done;
    res_full  = (res_cnt == RW'(CHANNELS));
    res_wr    = ((state == FEED) || (state == WAIT)) && pool_out_valid && !res_full;
    last_in   = (in_cnt == IW'(TOTAL - 1));
    last_chan = (idx == CW'(CHANNELS - 1));
    wr_idx    = res_cnt[CW-1:0];
  end

  // Next-state logic and combinational outputs.
  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    s_ready  = (state == FEED);
    pool_clr = start_acc && !rst;
    m_valid  = (state == DRAIN);
    m_data   = '0;
    m_chan   = '0;
    m_last   = 1'b0;
    if (state == DRAIN) begin
      m_data = res_buf[idx];
      m_chan = idx;
      m_last = last_chan;
    end
    unique case (state)
      IDLE:  if (start_acc) state_nx = FEED;
      FEED:  if (s_hs && last_in) state_nx = WAIT;
      WAIT:  if (timeout_hit) state_nx = IDLE;
             else if (res_full) state_nx = DRAIN;
      DRAIN: if (m_hs && last_chan) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Counters, result buffer, pooling-unit feed register and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt        <= '0;
      res_cnt       <= '0;
      idx           <= '0;
      pool_in_valid <= 1'b0;
      pool_in_data  <= '0;
      done          <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) res_buf[i] <= '0;
    end else begin
      pool_in_valid <= s_hs;
      if (s_hs) pool_in_data <= s_data;
      done <= m_hs && last_chan;
      if (start_acc) begin
        in_cnt  <= '0;
        res_cnt <= '0;
        idx     <= '0;
      end else begin
        if (s_hs) in_cnt <= in_cnt + IW'(1);
        if (res_wr) begin
          res_buf[wr_idx] <= pool_out_data;
          res_cnt         <= res_cnt + RW'(1);
        end
        if (m_hs) idx <= last_chan ? '0 : idx + CW'(1);
      end
    end
  end

`ifdef SE_POOL_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          err_q;

  assign timeout_hit = (state == WAIT) && !pool_out_valid &&
                       (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  // Watchdog: counts idle WAIT cycles, restarts on every pooling result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state != WAIT) || pool_out_valid) wd_cnt <= '0;
      else                                   wd_cnt <= wd_cnt + TW'(1);
      if (timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
